// File: rtl/key_pkg.sv
// Shared definitions for the key entry parser.
// Holds the ASCII codes the parser reacts to, the FSM state encoding,
// the command-match bundle produced by the classifier, and a letter
// matching helper that optionally folds case.
package key_pkg;

    localparam logic [7:0] ASCII_ESC  = 8'h1B;
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_AT   = 8'h40;
    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_FIVE = 8'h35;
    localparam logic [7:0] ASCII_NINE = 8'h39;
    localparam logic [7:0] ASCII_LC_A = 8'h61;
    localparam logic [7:0] ASCII_LC_L = 8'h6C;
    localparam logic [7:0] ASCII_LC_N = 8'h6E;
    localparam logic [7:0] ASCII_LC_S = 8'h73;
    // Setting this bit maps an uppercase ASCII letter onto its lowercase form.
    localparam logic [7:0] ASCII_CASE_BIT = 8'h20;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_COLLECT = 1'b1
    } key_state_e;

    typedef struct packed {
        logic esc;
        logic cr;
        logic at;
        logic a;
        logic l;
        logic n;
        logic s;
    } cmd_match_t;

    // Compare a byte against a lowercase letter, optionally ignoring case.
    function automatic logic match_letter(input logic [7:0] c,
                                          input logic [7:0] lc,
                                          input logic       fold);
        logic [7:0] folded;
        folded = fold ? (c | ASCII_CASE_BIT) : c;
        return (folded == lc);
    endfunction

endpackage

// File: rtl/key_classify.sv
// Combinational byte classifier.
// Ports:
//   char_data  in  8  ASCII byte to classify
//   is_digit   out 1  byte is '0'..'9'
//   digit      out 4  numeric value of the digit (0 when not a digit)
//   lt6        out 1  byte is '0'..'5'
//   cmd        out    ESC / CR / '@' / a / l / n / s match flags
module key_classify
    import key_pkg::*;
#(
    parameter bit CASE_FOLD = 1'b1
) (
    input  logic [7:0] char_data,
    output logic       is_digit,
    output logic [3:0] digit,
    output logic       lt6,
    output cmd_match_t cmd
);

    // Decode digit class and command matches for the current byte.
    always_comb begin
        is_digit = (char_data >= ASCII_ZERO) && (char_data <= ASCII_NINE);
        lt6      = (char_data >= ASCII_ZERO) && (char_data <= ASCII_FIVE);
        // '0'..'9' are 8'h30..8'h39, so the low nibble already is the value.
        if (is_digit) begin
            digit = char_data[3:0];
        end else begin
            digit = 4'h0;
        end
        cmd.esc = (char_data == ASCII_ESC);
        cmd.cr  = (char_data == ASCII_CR);
        cmd.at  = (char_data == ASCII_AT);
        cmd.a   = match_letter(char_data, ASCII_LC_A, CASE_FOLD);
        cmd.l   = match_letter(char_data, ASCII_LC_L, CASE_FOLD);
        cmd.n   = match_letter(char_data, ASCII_LC_N, CASE_FOLD);
        cmd.s   = match_letter(char_data, ASCII_LC_S, CASE_FOLD);
    end

endmodule

// File: rtl/key_entry_parser.sv
// Keyboard command decoder and '@'-prefixed BCD time-entry collector.
// Single-byte commands pulse det_* while idle; '@' opens an entry of
// NUM_DIGITS digits, each range-checked against SIX_MASK, which commits
// to entry_value or is rejected via entry_error. ESC abandons an entry
// silently; an optional inactivity timeout rejects a stalled entry.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   charData, charDataValid  incoming byte and its one-cycle qualifier
//   det_esc .. det_S         registered one-cycle command pulses
//   entry_active             high while an entry is being collected
//   entry_valid/entry_error  one-cycle commit / reject pulses
//   entry_value              last committed value, first digit in MS nibble
module key_entry_parser
    import key_pkg::*;
#(
    parameter int                    NUM_DIGITS     = 4,
    parameter logic [NUM_DIGITS-1:0] SIX_MASK       = 4'b1010,
    parameter bit                    CASE_FOLD      = 1'b1,
    parameter int                    TIMEOUT_CYCLES = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [7:0]                charData,
    input  logic                      charDataValid,
    output logic                      det_esc,
    output logic                      det_cr,
    output logic                      det_atSign,
    output logic                      det_A,
    output logic                      det_L,
    output logic                      det_N,
    output logic                      det_S,
    output logic                      entry_active,
    output logic                      entry_valid,
    output logic                      entry_error,
    output logic [4*NUM_DIGITS-1:0]   entry_value
);

    localparam int VAL_W  = 4 * NUM_DIGITS;
    localparam int IDX_W  = $clog2(NUM_DIGITS + 1);
    localparam int CNT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit TMO_EN = (TIMEOUT_CYCLES > 0);

    key_state_e        state_r;
    logic [IDX_W-1:0]  idx_r;
    logic [VAL_W-1:0]  shadow_r;
    logic [CNT_W-1:0]  cnt_r;

    logic              is_digit_s;
    logic [3:0]        digit_s;
    logic              lt6_s;
    cmd_match_t        cmd_s;
    logic              six_req_s;
    logic              digit_legal_s;
    logic              last_digit_s;
    logic              tmo_hit_s;
    logic [VAL_W-1:0]  shadow_nx_s;

    key_classify #(
        .CASE_FOLD (CASE_FOLD)
    ) u_classify (
        .char_data (charData),
        .is_digit  (is_digit_s),
        .digit     (digit_s),
        .lt6       (lt6_s),
        .cmd       (cmd_s)
    );

    // Look up whether the digit position about to be filled is limited to 0-5.
    // Position idx counts from the first typed digit, i.e. from the mask MSB.
    always_comb begin
        six_req_s = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            six_req_s = six_req_s | ((idx_r == IDX_W'(i)) & SIX_MASK[NUM_DIGITS-1-i]);
        end
    end

    assign digit_legal_s = is_digit_s & (~six_req_s | lt6_s);
    assign last_digit_s  = (idx_r == IDX_W'(NUM_DIGITS - 1));
    assign shadow_nx_s   = (shadow_r << 4) | VAL_W'(digit_s);
    // Fires on the idle cycle that would bring the counter up to the limit.
    assign tmo_hit_s     = TMO_EN && (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));

    // Entry FSM, shadow/index/timeout state and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            idx_r        <= '0;
            shadow_r     <= '0;
            cnt_r        <= '0;
            det_esc      <= 1'b0;
            det_cr       <= 1'b0;
            det_atSign   <= 1'b0;
            det_A        <= 1'b0;
            det_L        <= 1'b0;
            det_N        <= 1'b0;
            det_S        <= 1'b0;
            entry_active <= 1'b0;
            entry_valid  <= 1'b0;
            entry_error  <= 1'b0;
            entry_value  <= '0;
        end else begin
            det_esc     <= 1'b0;
            det_cr      <= 1'b0;
            det_atSign  <= 1'b0;
            det_A       <= 1'b0;
            det_L       <= 1'b0;
            det_N       <= 1'b0;
            det_S       <= 1'b0;
            entry_valid <= 1'b0;
            entry_error <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (charDataValid) begin
                        det_esc    <= cmd_s.esc;
                        det_cr     <= cmd_s.cr;
                        det_atSign <= cmd_s.at;
                        det_A      <= cmd_s.a;
                        det_L      <= cmd_s.l;
                        det_N      <= cmd_s.n;
                        det_S      <= cmd_s.s;
                        if (cmd_s.at) begin
                            state_r      <= ST_COLLECT;
                            idx_r        <= '0;
                            shadow_r     <= '0;
                            cnt_r        <= '0;
                            entry_active <= 1'b1;
                        end
                    end
                end
                ST_COLLECT: begin
                    // A byte always takes priority over an expiring timeout.
                    if (charDataValid) begin
                        if (cmd_s.esc) begin
                            det_esc      <= 1'b1;
                            state_r      <= ST_IDLE;
                            entry_active <= 1'b0;
                        end else if (digit_legal_s) begin
                            shadow_r <= shadow_nx_s;
                            idx_r    <= idx_r + IDX_W'(1);
                            cnt_r    <= '0;
                            if (last_digit_s) begin
                                entry_value  <= shadow_nx_s;
                                entry_valid  <= 1'b1;
                                state_r      <= ST_IDLE;
                                entry_active <= 1'b0;
                            end
                        end else begin
                            entry_error  <= 1'b1;
                            state_r      <= ST_IDLE;
                            entry_active <= 1'b0;
                        end
                    end else if (tmo_hit_s) begin
                        entry_error  <= 1'b1;
                        state_r      <= ST_IDLE;
                        entry_active <= 1'b0;
                    end else if (TMO_EN) begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    entry_active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_entry_parser.sv
// Bench for key_entry_parser. Three instances share one byte stream:
//   0: defaults (case folding, no timeout)
//   1: lowercase-only commands
//   2: defaults with a 10-cycle inactivity timeout
// A behavioural model predicts every output of every instance each cycle;
// literal checks on pulse counts and values pin the model.
module tb_key_entry_parser;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid = 1'b0;
    logic [7:0] data = 8'h00;

    always #5 clk = ~clk;

    logic        d_esc [3];
    logic        d_cr  [3];
    logic        d_at  [3];
    logic        d_a   [3];
    logic        d_l   [3];
    logic        d_n   [3];
    logic        d_s   [3];
    logic        act   [3];
    logic        ev    [3];
    logic        ee    [3];
    logic [15:0] val   [3];

    key_entry_parser #(.CASE_FOLD(1'b1), .TIMEOUT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .charData(data), .charDataValid(valid),
        .det_esc(d_esc[0]), .det_cr(d_cr[0]), .det_atSign(d_at[0]),
        .det_A(d_a[0]), .det_L(d_l[0]), .det_N(d_n[0]), .det_S(d_s[0]),
        .entry_active(act[0]), .entry_valid(ev[0]), .entry_error(ee[0]),
        .entry_value(val[0]));

    key_entry_parser #(.CASE_FOLD(1'b0), .TIMEOUT_CYCLES(0)) dut1 (
        .clk(clk), .rst(rst), .charData(data), .charDataValid(valid),
        .det_esc(d_esc[1]), .det_cr(d_cr[1]), .det_atSign(d_at[1]),
        .det_A(d_a[1]), .det_L(d_l[1]), .det_N(d_n[1]), .det_S(d_s[1]),
        .entry_active(act[1]), .entry_valid(ev[1]), .entry_error(ee[1]),
        .entry_value(val[1]));

    key_entry_parser #(.CASE_FOLD(1'b1), .TIMEOUT_CYCLES(10)) dut2 (
        .clk(clk), .rst(rst), .charData(data), .charDataValid(valid),
        .det_esc(d_esc[2]), .det_cr(d_cr[2]), .det_atSign(d_at[2]),
        .det_A(d_a[2]), .det_L(d_l[2]), .det_N(d_n[2]), .det_S(d_s[2]),
        .entry_active(act[2]), .entry_valid(ev[2]), .entry_error(ee[2]),
        .entry_value(val[2]));

    int n_cmp  = 0;
    int n_fail = 0;

    // Model state per instance.
    int fold_p [3] = '{1, 0, 1};
    int tmo_p  [3] = '{0, 0, 10};
    bit          m_act  [3];
    int          m_nd   [3];
    int          m_idle [3];
    logic [15:0] m_acc  [3];
    logic [15:0] m_val  [3];
    logic [25:0] m_exp  [3];

    // Observed pulse counts, cleared by the stimulus between scenarios.
    int c_esc [3], c_cr [3], c_at [3], c_a [3], c_l [3], c_n [3], c_s [3];
    int c_v [3], c_e [3], c_act [3];

    logic [6:0]  mp;
    bit          mv, me;
    logic [25:0] obs;

    function automatic bit lmatch(input logic [7:0] c, input logic [7:0] lc, input int fold);
        if (fold != 0) return ((c | 8'h20) == lc);
        return (c == lc);
    endfunction

    // With the default mask 1010 the 1st and 3rd typed digits must be 0-5.
    function automatic bit legal(input int nd, input logic [7:0] c);
        if (c < 8'h30 || c > 8'h39) return 1'b0;
        if (nd == 0 || nd == 2) return (c <= 8'h35);
        return 1'b1;
    endfunction

    task automatic check(input string nm, input int a, input int e);
        n_cmp++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h expected 'h%0h", nm, a, e);
        end
    endtask

    task automatic clear_counts();
        for (int i = 0; i < 3; i++) begin
            c_esc[i] = 0; c_cr[i] = 0; c_at[i] = 0; c_a[i] = 0; c_l[i] = 0;
            c_n[i] = 0; c_s[i] = 0; c_v[i] = 0; c_e[i] = 0; c_act[i] = 0;
        end
    endtask

    task automatic cyc(input logic v, input logic [7:0] c);
        @(negedge clk);
        valid = v;
        data  = c;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 8'h00);
    endtask

    task automatic send(input string s);
        for (int k = 0; k < s.len(); k++) cyc(1'b1, s[k]);
    endtask

    // Model update on each edge, then compare all instances just after it.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            mp = 7'b0; mv = 1'b0; me = 1'b0;
            if (rst) begin
                m_act[i] = 1'b0; m_nd[i] = 0; m_idle[i] = 0;
                m_acc[i] = 16'h0; m_val[i] = 16'h0;
            end else if (!m_act[i]) begin
                if (valid) begin
                    mp[6] = (data == 8'h1B);
                    mp[5] = (data == 8'h0D);
                    mp[4] = (data == 8'h40);
                    mp[3] = lmatch(data, 8'h61, fold_p[i]);
                    mp[2] = lmatch(data, 8'h6C, fold_p[i]);
                    mp[1] = lmatch(data, 8'h6E, fold_p[i]);
                    mp[0] = lmatch(data, 8'h73, fold_p[i]);
                    if (data == 8'h40) begin
                        m_act[i] = 1'b1; m_nd[i] = 0; m_acc[i] = 16'h0; m_idle[i] = 0;
                    end
                end
            end else begin
                if (valid) begin
                    if (data == 8'h1B) begin
                        mp[6] = 1'b1;
                        m_act[i] = 1'b0;
                    end else if (legal(m_nd[i], data)) begin
                        m_acc[i] = m_acc[i] * 16'd16 + 16'(data - 8'h30);
                        m_nd[i]++;
                        m_idle[i] = 0;
                        if (m_nd[i] == 4) begin
                            m_val[i] = m_acc[i];
                            mv = 1'b1;
                            m_act[i] = 1'b0;
                        end
                    end else begin
                        me = 1'b1;
                        m_act[i] = 1'b0;
                    end
                end else if (tmo_p[i] > 0) begin
                    m_idle[i]++;
                    if (m_idle[i] == tmo_p[i]) begin
                        me = 1'b1;
                        m_act[i] = 1'b0;
                    end
                end
            end
            m_exp[i] = {mp, m_act[i], mv, me, m_val[i]};
        end
        #1;
        for (int i = 0; i < 3; i++) begin
            obs = {d_esc[i], d_cr[i], d_at[i], d_a[i], d_l[i], d_n[i], d_s[i],
                   act[i], ev[i], ee[i], val[i]};
            n_cmp++;
            if (obs !== m_exp[i]) begin
                n_fail++;
                $display("FAIL cycle_cmp inst%0d t=%0t: got %h expected %h", i, $time, obs, m_exp[i]);
            end
            c_esc[i] += int'(d_esc[i]); c_cr[i] += int'(d_cr[i]); c_at[i] += int'(d_at[i]);
            c_a[i] += int'(d_a[i]); c_l[i] += int'(d_l[i]); c_n[i] += int'(d_n[i]);
            c_s[i] += int'(d_s[i]); c_v[i] += int'(ev[i]); c_e[i] += int'(ee[i]);
            c_act[i] += int'(act[i]);
        end
    end

    initial begin
        clear_counts();
        idle(3);
        check("reset_value", int'(val[0]), 0);
        check("reset_active", int'(act[0]), 0);
        @(negedge clk);
        rst = 1'b0;
        idle(2);

        // Single-byte commands, with and without case folding.
        clear_counts();
        send("aLnS"); cyc(1'b1, 8'h0D); cyc(1'b1, 8'h1B); idle(2);
        check("fold_A", c_a[0], 1);
        check("fold_L", c_l[0], 1);
        check("fold_N", c_n[0], 1);
        check("fold_S", c_s[0], 1);
        check("fold_cr", c_cr[0], 1);
        check("fold_esc", c_esc[0], 1);
        check("nofold_A", c_a[1], 1);
        check("nofold_L", c_l[1], 0);
        check("nofold_N", c_n[1], 1);
        check("nofold_S", c_s[1], 0);

        // Back-to-back full entry.
        clear_counts();
        send("@1234"); idle(2);
        check("commit_valid", c_v[0], 1);
        check("commit_value", int'(val[0]), 'h1234);
        check("commit_active_cycles", c_act[0], 4);
        check("commit_at", c_at[0], 1);

        // Third digit limited to 0-5: '7' rejects, trailing '4' is ignored.
        clear_counts();
        send("@1274"); idle(2);
        check("range_err", c_e[0], 1);
        check("range_no_valid", c_v[0], 0);
        check("range_hold", int'(val[0]), 'h1234);

        // Second digit is unrestricted under the default mask.
        clear_counts();
        send("@1734"); idle(2);
        check("pos2_commit", c_v[0], 1);
        check("pos2_value", int'(val[0]), 'h1734);

        // First digit limited to 0-5.
        clear_counts();
        send("@6"); idle(2);
        check("first_digit_err", c_e[0], 1);

        // ESC aborts quietly; CR inside an entry is an error, not a command.
        clear_counts();
        send("@12"); cyc(1'b1, 8'h1B); idle(2);
        check("esc_abort_esc", c_esc[0], 1);
        check("esc_abort_noerr", c_e[0], 0);
        clear_counts();
        send("@12"); cyc(1'b1, 8'h0D); idle(2);
        check("cr_err", c_e[0], 1);
        check("cr_no_det", c_cr[0], 0);

        // Timeout: 10 idle cycles after a digit aborts the entry.
        clear_counts();
        send("@1"); idle(10); idle(2);
        check("tmo_err", c_e[2], 1);
        check("tmo_none_when_disabled", c_e[0], 0);
        cyc(1'b1, 8'h1B); idle(2);

        // Timeout boundary: a digit on the 10th cycle keeps the entry alive.
        clear_counts();
        send("@1"); idle(9); send("259"); idle(2);
        check("tmo_edge_noerr", c_e[2], 0);
        check("tmo_edge_commit", c_v[2], 1);
        check("tmo_edge_value", int'(val[2]), 'h1259);

        // Reset mid-entry, then a fresh entry.
        clear_counts();
        send("@12");
        @(negedge clk); valid = 1'b0; rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        idle(1);
        check("rst_value", int'(val[0]), 0);
        check("rst_active", int'(act[0]), 0);
        check("rst_no_err", c_e[0], 0);
        clear_counts();
        send("@5959"); idle(2);
        check("post_rst_commit", c_v[0], 1);
        check("post_rst_value", int'(val[0]), 'h5959);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
